booth_mul_seq: RTL and testbench

Iterative radix-4 Booth multiplier: a parametrised, multi-cycle successor to the datapath's single-cycle combinational `mul_32`. It processes one Booth digit (two multiplier bits) per clock and supports signed or unsigned operands, selected per operation. A start/busy/done handshake lets the control unit stall on MUL while the datapath holds a full double-width product for the HI/LO registers.

---
 rtl/mul_pkg.sv | 27 ++
 rtl/booth_recode.sv | 24 ++
 rtl/booth_mul_seq.sv | 127 ++++++++++++
 tb/tb_booth_mul_seq.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared definitions for the Booth multiplier family.
//   state_t      : sequencer state encoding (IDLE / RUN / DONE)
//   booth_sel_t  : radix-4 Booth digit selection (ZERO, +/-1*M, +/-2*M)
//   n_digits()   : number of radix-4 digits processed for a given operand width
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    typedef enum logic [2:0] {
        ZERO = 3'd0,
        POS1 = 3'd1,
        POS2 = 3'd2,
        NEG1 = 3'd3,
        NEG2 = 3'd4
    } booth_sel_t;

    // Operands are widened by two bits so unsigned values recode correctly;
    // the widened operand holds (width+2)/2 radix-4 digits.
    function automatic int n_digits(input int width);
        return width / 2 + 1;
    endfunction

endpackage

// File: rtl/booth_recode.sv
// Radix-4 Booth recoder: maps a 3-bit overlapping multiplier group
// {q[2k+1], q[2k], q[2k-1]} to a partial-product selection.
//   group : in  3-bit multiplier group
//   sel   : out selection code (booth_sel_t)
module booth_recode
    import mul_pkg::*;
(
    input  logic [2:0]  group,
    output booth_sel_t  sel
);

    always_comb begin
        sel = ZERO;
        unique case (group)
            3'b000, 3'b111: sel = ZERO;
            3'b001, 3'b010: sel = POS1;
            3'b011:         sel = POS2;
            3'b100:         sel = NEG2;
            3'b101, 3'b110: sel = NEG1;
            default:        sel = ZERO;
        endcase
    end

endmodule

// File: rtl/booth_mul_seq.sv
// Iterative radix-4 Booth multiplier, one Booth digit per clock.
//   clock       : in  rising-edge clock
//   clear       : in  asynchronous active-low reset
//   start       : in  request a multiply (accepted in IDLE or DONE)
//   signed_mode : in  1 = two's-complement operands, 0 = unsigned
//   M, Q        : in  multiplicand / multiplier, captured with start
//   busy        : out high while digits are being processed
//   done        : out one-cycle pulse when P holds a new product
//   P           : out 2*WIDTH-bit product, held until the next result
module booth_mul_seq
    import mul_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clock,
    input  logic                 clear,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     M,
    input  logic [WIDTH-1:0]     Q,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   P
);

    localparam int E  = WIDTH + 2;
    localparam int N  = n_digits(WIDTH);
    localparam int KW = $clog2(N);

    state_t          state;
    logic [E-1:0]    mx;
    logic [E-1:0]    qx;         // shifts right two bits per digit
    logic            lookback;   // q[2k-1] of the current digit
    logic [2*E-1:0]  acc;
    logic [KW-1:0]   k;

    logic [E-1:0]    m_ext;
    logic [E-1:0]    q_ext;
    logic            accept;
    logic            last;
    booth_sel_t      sel;
    logic [E:0]      mx_wide;
    logic [E:0]      pp;
    logic [2*E-1:0]  pp_sext;
    logic [KW:0]     shamt;
    logic [2*E-1:0]  acc_next;

    // The operand mode lives on only through how Mx/Qx are extended here.
    assign m_ext = signed_mode ? {{2{M[WIDTH-1]}}, M} : {2'b00, M};
    assign q_ext = signed_mode ? {{2{Q[WIDTH-1]}}, Q} : {2'b00, Q};

    assign accept = start && ((state == IDLE) || (state == DONE));
    assign last   = (k == KW'(N - 1));

    booth_recode u_recode (
        .group ({qx[1], qx[0], lookback}),
        .sel   (sel)
    );

    // Partial product is E+1 bits so that 2*Mx and its negation both fit.
    assign mx_wide = {mx[E-1], mx};

    always_comb begin
        pp = '0;
        unique case (sel)
            ZERO:    pp = '0;
            POS1:    pp = mx_wide;
            POS2:    pp = {mx, 1'b0};
            NEG1:    pp = -mx_wide;
            NEG2:    pp = -{mx, 1'b0};
            default: pp = '0;
        endcase
    end

    assign pp_sext  = {{(E-1){pp[E]}}, pp};
    assign shamt    = {k, 1'b0};
    assign acc_next = acc + (pp_sext << shamt);

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            P        <= '0;
            mx       <= '0;
            qx       <= '0;
            lookback <= 1'b0;
            acc      <= '0;
            k        <= '0;
        end else if (accept) begin
            state    <= RUN;
            busy     <= 1'b1;
            done     <= 1'b0;
            mx       <= m_ext;
            qx       <= q_ext;
            lookback <= 1'b0;
            acc      <= '0;
            k        <= '0;
        end else begin
            unique case (state)
                RUN: begin
                    acc      <= acc_next;
                    qx       <= qx >> 2;
                    lookback <= qx[1];
                    k        <= k + 1'b1;
                    if (last) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        // Full product fits in 2*WIDTH bits in both modes.
                        P     <= acc_next[2*WIDTH-1:0];
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mul_seq.sv
module tb_booth_mul_seq;

    logic        clock = 1'b0;
    logic        clear;
    logic        start, sm;
    logic [31:0] m, q;
    logic        busy, done;
    logic [63:0] p;

    logic        start8, sm8;
    logic [7:0]  m8, q8;
    logic        busy8, done8;
    logic [15:0] p8;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    booth_mul_seq #(.WIDTH(32)) dut (
        .clock(clock), .clear(clear), .start(start), .signed_mode(sm),
        .M(m), .Q(q), .busy(busy), .done(done), .P(p)
    );

    booth_mul_seq #(.WIDTH(8)) dut8 (
        .clock(clock), .clear(clear), .start(start8), .signed_mode(sm8),
        .M(m8), .Q(q8), .busy(busy8), .done(done8), .P(p8)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Issue one 32-bit op; operands are scrambled right after acceptance.
    task automatic op32(input logic [31:0] a, input logic [31:0] b, input logic s,
                        output logic [63:0] res, output int lat, output int busy_cyc);
        m = a; q = b; sm = s; start = 1'b1;
        tick();
        start = 1'b0; m = ~a; q = 32'h5a5a_c3c3; sm = ~s;
        lat = 0; busy_cyc = 0;
        if (busy) busy_cyc++;
        while (!done && lat < 100) begin
            tick();
            lat++;
            if (busy) busy_cyc++;
        end
        res = p;
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s,
                       output logic [15:0] res, output int lat);
        m8 = a; q8 = b; sm8 = s; start8 = 1'b1;
        tick();
        start8 = 1'b0; m8 = ~a; q8 = ~b;
        lat = 0;
        while (!done8 && lat < 40) begin
            tick();
            lat++;
        end
        res = p8;
    endtask

    task automatic test_reset();
        clear = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (p !== 64'd0) begin n_bad++; $display("FAIL reset_p: got %h want 0", p); end
        n_cmp++; if (busy8 !== 1'b0) begin n_bad++; $display("FAIL reset_busy8: got %b want 0", busy8); end
        n_cmp++; if (done8 !== 1'b0) begin n_bad++; $display("FAIL reset_done8: got %b want 0", done8); end
        n_cmp++; if (p8 !== 16'd0) begin n_bad++; $display("FAIL reset_p8: got %h want 0", p8); end
        tick();
        tick();
        clear = 1'b1;
        tick();
    endtask

    task automatic test_signed_basic();
        logic [63:0] r;
        int lat, bc;
        op32(32'd7, 32'hFFFF_FFFD, 1'b1, r, lat, bc);
        n_cmp++; if (r !== 64'hFFFF_FFFF_FFFF_FFEB) begin n_bad++; $display("FAIL basic_p: got %h want ffffffffffffffeb", r); end
        n_cmp++; if (lat !== 17) begin n_bad++; $display("FAIL basic_latency: got %0d want 17", lat); end
        n_cmp++; if (bc !== 17) begin n_bad++; $display("FAIL basic_busy_cycles: got %0d want 17", bc); end
        repeat (3) tick();
        n_cmp++; if (p !== 64'hFFFF_FFFF_FFFF_FFEB) begin n_bad++; $display("FAIL basic_p_hold: got %h want ffffffffffffffeb", p); end
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL basic_idle: got busy=%b done=%b want 0 0", busy, done); end
    endtask

    task automatic test_signed_unsigned();
        logic [31:0] va [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};
        logic        vs [3] = '{1'b1, 1'b0, 1'b1};
        logic [63:0] ve [3] = '{64'h0000_0000_0000_0001, 64'hFFFF_FFFE_0000_0001, 64'h4000_0000_0000_0000};
        logic [63:0] r;
        int lat, bc;
        for (int i = 0; i < 3; i++) begin
            op32(va[i], va[i], vs[i], r, lat, bc);
            n_cmp++; if (r !== ve[i]) begin n_bad++; $display("FAIL mode_p%0d: got %h want %h", i, r, ve[i]); end
            n_cmp++; if (lat !== 17) begin n_bad++; $display("FAIL mode_latency%0d: got %0d want 17", i, lat); end
            tick();
        end
    endtask

    task automatic test_handshake();
        int cyc, bc;
        m = 32'd6; q = 32'd7; sm = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0; bc = 0;
        if (busy) bc++;
        while (!done && cyc < 100) begin
            if (cyc == 4) begin
                m = 32'd100; q = 32'd100; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
            cyc++;
            if (busy) bc++;
        end
        start = 1'b0;
        n_cmp++; if (cyc !== 17) begin n_bad++; $display("FAIL hs_done_cycle: got %0d want 17", cyc); end
        n_cmp++; if (p !== 64'd42) begin n_bad++; $display("FAIL hs_p: got %h want 2a", p); end
        n_cmp++; if (bc !== 17) begin n_bad++; $display("FAIL hs_busy_cycles: got %0d want 17", bc); end
        tick();
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL hs_done_width: got %b want 0", done); end
        n_cmp++; if (busy !== 1'b0 || p !== 64'd42) begin n_bad++; $display("FAIL hs_after: got busy=%b p=%h want 0 2a", busy, p); end
        tick();
    endtask

    task automatic test_back_to_back();
        int cyc, nd, c1, c2;
        logic [63:0] p1, p2;
        m = 32'd3; q = 32'd5; sm = 1'b1; start = 1'b1;
        tick();
        m = 32'hFFFF_FFFE; q = 32'd9;
        cyc = 0; nd = 0; c1 = -1; c2 = -1; p1 = '0; p2 = '0;
        while (cyc < 60) begin
            tick();
            cyc++;
            if (done) begin
                nd++;
                if (nd == 1) begin c1 = cyc; p1 = p; end
                else begin c2 = cyc; p2 = p; end
            end
            if (cyc == 18) begin
                n_cmp++; if (busy !== 1'b1 || done !== 1'b0) begin n_bad++; $display("FAIL b2b_handover: got busy=%b done=%b want 1 0", busy, done); end
                start = 1'b0;
            end
        end
        n_cmp++; if (nd !== 2) begin n_bad++; $display("FAIL b2b_count: got %0d want 2", nd); end
        n_cmp++; if (c1 !== 17) begin n_bad++; $display("FAIL b2b_first_cycle: got %0d want 17", c1); end
        n_cmp++; if (c2 !== 35) begin n_bad++; $display("FAIL b2b_second_cycle: got %0d want 35", c2); end
        n_cmp++; if (p1 !== 64'd15) begin n_bad++; $display("FAIL b2b_p1: got %h want f", p1); end
        n_cmp++; if (p2 !== 64'hFFFF_FFFF_FFFF_FFEE) begin n_bad++; $display("FAIL b2b_p2: got %h want ffffffffffffffee", p2); end
    endtask

    task automatic test_mid_reset();
        int nd;
        logic [63:0] r;
        int lat, bc;
        m = 32'd1000; q = 32'd1000; sm = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (8) tick();
        clear = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL midrst_done: got %b want 0", done); end
        n_cmp++; if (p !== 64'd0) begin n_bad++; $display("FAIL midrst_p: got %h want 0", p); end
        #2;
        clear = 1'b1;
        nd = 0;
        repeat (30) begin
            tick();
            if (done || busy) nd++;
        end
        n_cmp++; if (nd !== 0) begin n_bad++; $display("FAIL midrst_no_done: got %0d active cycles want 0", nd); end
        op32(32'd123, 32'hFFFF_FFD3, 1'b1, r, lat, bc);
        n_cmp++; if (r !== 64'hFFFF_FFFF_FFFF_EA61) begin n_bad++; $display("FAIL midrst_after_p: got %h want ffffffffffffea61", r); end
        n_cmp++; if (lat !== 17) begin n_bad++; $display("FAIL midrst_after_latency: got %0d want 17", lat); end
        tick();
    endtask

    task automatic test_width8_random();
        logic [7:0]  a, b;
        logic        s;
        logic [15:0] r, e;
        int lat, ia, ib;
        for (int i = 0; i < 4000; i++) begin
            if (i < 4) begin
                a = (i[0]) ? 8'h80 : 8'hFF;
                b = a;
                s = i[1];
            end else begin
                a = 8'($urandom);
                b = 8'($urandom);
                s = 1'($urandom);
            end
            ia = s ? int'($signed(a)) : int'({24'd0, a});
            ib = s ? int'($signed(b)) : int'({24'd0, b});
            e  = 16'(ia * ib);
            op8(a, b, s, r, lat);
            n_cmp++;
            if (r !== e || lat !== 5) begin
                n_bad++;
                $display("FAIL w8_vec%0d (%h*%h s=%b): got P=%h lat=%0d want P=%h lat=5", i, a, b, s, r, lat, e);
            end
        end
    endtask

    initial begin
        start = 1'b0; sm = 1'b0; m = '0; q = '0;
        start8 = 1'b0; sm8 = 1'b0; m8 = '0; q8 = '0;
        test_reset();
        test_signed_basic();
        test_signed_unsigned();
        test_handshake();
        test_back_to_back();
        test_mid_reset();
        test_width8_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
